rr_arbiter_8: RTL and testbench

Eight-requester round-robin arbiter with grant hold and hold-timeout. It sits directly upstream of the 8-to-3 encoder. Its `grant` vector drives the encoder's `in` port and is guaranteed to be all-zero or exactly one-hot, so the encoder never sees an invalid input. It also provides a registered binary `grant_idx`, which must equal the encoder's output whenever `grant_valid` is high.

---
 rtl/rr_arbiter_8.sv | 115 +++++++++++
 tb/tb_rr_arbiter_8.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with grant hold, hold-timeout and a one-cycle release bubble.
// grant is always zero or one-hot; grant_idx is its binary encoding.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic       timeout
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt;
    logic [N-1:0]       grant_nxt;
    logic               grant_valid_nxt;
    logic [IDX_W-1:0]   grant_idx_nxt;
    logic               timeout_nxt;
    logic [IDX_W-1:0]   winner;
    logic               winner_found;

    // First set request scanning upward from ptr with wrap-around.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!winner_found && req[ptr + IDX_W'(i)]) begin
                winner       = ptr + IDX_W'(i);
                winner_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        hold_nxt        = hold_cnt;
        grant_nxt       = grant;
        grant_valid_nxt = grant_valid;
        grant_idx_nxt   = grant_idx;
        timeout_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (winner_found) begin
                    grant_nxt       = N'(1) << winner;
                    grant_valid_nxt = 1'b1;
                    grant_idx_nxt   = winner;
                    hold_nxt        = CNT_W'(1);
                    state_nxt       = BUSY;
                end
            end
            BUSY: begin
                hold_nxt = hold_cnt + CNT_W'(1);
                // done wins over a coincident timeout, so no pulse in that case
                if (done || (hold_cnt == HOLD_LIMIT)) begin
                    timeout_nxt     = !done;
                    ptr_nxt         = grant_idx + IDX_W'(1);
                    grant_nxt       = '0;
                    grant_valid_nxt = 1'b0;
                    grant_idx_nxt   = '0;
                    hold_nxt        = '0;
                    state_nxt       = RELEASE;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt       = '0;
                grant_valid_nxt = 1'b0;
                grant_idx_nxt   = '0;
                hold_nxt        = '0;
                state_nxt       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            grant       <= grant_nxt;
            grant_valid <= grant_valid_nxt;
            grant_idx   <= grant_idx_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD = 4) plus a random one-hot/encoding sweep.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout;

    int total;
    int bad;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 8-to-3 encoder fed from grant.
    function automatic logic [2:0] enc8(input logic [7:0] g);
        enc8 = '0;
        for (int i = 0; i < 8; i++)
            if (g[i]) enc8 = 3'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                           input logic to);
        chk({tag, ".grant"},       32'(grant),       32'(g));
        chk({tag, ".grant_valid"}, 32'(grant_valid), 32'(g != 8'h00));
        chk({tag, ".grant_idx"},   32'(grant_idx),   32'(idx));
        chk({tag, ".timeout"},     32'(timeout),     32'(to));
    endtask

    initial begin
        logic [7:0] g_exp;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 8'hFF;
        done  = 1'b0;

        // Reset with all requests pending
        tick();
        tick();
        chk_out("reset", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("first_grant", 8'h01, 3'd0, 1'b0);

        // Rotation: release-bubble, idle evaluation, then next grant
        for (int k = 1; k <= 8; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            chk_out("rot_release", 8'h00, 3'd0, 1'b0);
            tick();
            chk_out("rot_idle", 8'h00, 3'd0, 1'b0);
            tick();
            g_exp = 8'd1 << (k % 8);
            chk_out("rot_grant", g_exp, 3'(k % 8), 1'b0);
            chk("rot_encoder", 32'(enc8(grant)), 32'(grant_idx));
        end

        // Pointer skip and wrap: grant 5, then scan 6,7,0 -> 0, then scan 1,2 -> 2
        req  = 8'h20;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk_out("grant5", 8'h20, 3'd5, 1'b0);
        req  = 8'b0000_0101;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk_out("wrap_to_0", 8'h01, 3'd0, 1'b0);
        req  = 8'b1000_0100;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk_out("skip_to_2", 8'h04, 3'd2, 1'b0);

        // Timeout: only requester 3, done never raised
        req  = 8'h08;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 4; c++) chk_out("hold", 8'h08, 3'd3, 1'b0);
        for (int c = 1; c < 4; c++) begin
            tick();
            chk_out("hold_cycle", 8'h08, 3'd3, 1'b0);
        end
        tick();
        chk_out("forced_release", 8'h00, 3'd0, 1'b1);
        tick();
        chk_out("after_timeout", 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("regrant3", 8'h08, 3'd3, 1'b0);

        // done coinciding with the hold limit: plain release, no pulse
        tick();
        tick();
        tick();
        chk_out("at_limit", 8'h08, 3'd3, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        chk_out("coincide_release", 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("coincide_idle", 8'h00, 3'd0, 1'b0);
        done = 1'b1;
        tick();
        chk_out("done_in_idle", 8'h00, 3'd0, 1'b0);
        req = 8'h08;
        tick();
        done = 1'b0;
        chk_out("grant_after_idle_done", 8'h08, 3'd3, 1'b0);

        // Reset mid-grant restores ptr to 0
        req  = 8'h40;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk_out("grant6", 8'h40, 3'd6, 1'b0);
        rst = 1'b1;
        req = 8'hFF;
        tick();
        chk_out("reset_mid_grant", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("post_reset_grant", 8'h01, 3'd0, 1'b0);

        // Random traffic: grant zero or one-hot, encoding consistent
        for (int c = 0; c < 200; c++) begin
            req  = 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            tick();
            chk("rand_onehot0", 32'($onehot0(grant)), 32'd1);
            chk("rand_valid", 32'(grant_valid), 32'(grant != 8'h00));
            chk("rand_idx", 32'(grant_idx), 32'(enc8(grant)));
            if (timeout) chk("rand_timeout_idle", 32'(grant), 32'd0);
        end
        done = 1'b0;
        req  = 8'h00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
